// File: rtl/me_sad_comparator.sv
`default_nettype none
// ============================================================================
// Module      : me_sad_comparator
// Description : Responder end of the motion-estimation comparator interface.
//               Consumes a per-candidate SAD stream, tracks the minimum SAD
//               and its {x,y} index, and presents the final motion vector
//               through a valid/ready result handshake once the search ends.
//               Optional feature macro: EARLY_EXIT_EN (early-termination
//               pulse when the best SAD drops to EARLY_THRESH or below).
// Revision    : 1.0 - initial release
// ============================================================================
module me_sad_comparator #(
  parameter int SAD_W        = 16,
  parameter int IDX_W        = 10,
  parameter int CNT_W        = 11,
  parameter int EARLY_THRESH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad,
  input  logic [IDX_W-1:0] sad_index,
  input  logic             done,
  input  logic             result_ready,
  output logic             result_valid,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_index,
  output logic [CNT_W-1:0] cand_count,
  output logic             busy,
  output logic             early_stop
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [SAD_W-1:0] c_sad_ones = {SAD_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [SAD_W-1:0] c_thresh   = SAD_W'(EARLY_THRESH);

  state_t           state_q, state_d;
  logic             done_dly_q, done_dly_d;
  logic             s1_valid_q, s1_valid_d;
  logic [SAD_W-1:0] s1_sad_q, s1_sad_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] cand_cnt_q, cand_cnt_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic             done_edge;
  logic             best_upd;

  // Next-state logic: FSM, stage-1 capture, stage-2 compare, init override
  always_comb begin
    state_d    = state_q;
    done_dly_d = done;
    s1_valid_d = 1'b0;
    s1_sad_d   = s1_sad_q;
    s1_idx_d   = s1_idx_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    cand_cnt_d = cand_cnt_q;
    done_edge  = done && !done_dly_q;
    best_upd   = 1'b0;

    // Stage 1: samples are only taken while the search is tracking
    if (sad_valid && (state_q == ST_TRACK)) begin
      s1_valid_d = 1'b1;
      s1_sad_d   = sad;
      s1_idx_d   = sad_index;
    end

    // Stage 2: strict less-than keeps the earliest of equal SADs
    if (s1_valid_q) begin
      if (cand_cnt_q != c_cnt_max) begin
        cand_cnt_d = cand_cnt_q + 1'b1;
      end
      if (s1_sad_q < best_sad_q) begin
        best_upd   = 1'b1;
        best_sad_d = s1_sad_q;
        best_idx_d = s1_idx_q;
      end
    end

    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_TRACK: if (done_edge) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD:  if (result_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A new search discards everything in flight, including this cycle's sample
    if (init) begin
      state_d    = ST_TRACK;
      s1_valid_d = 1'b0;
      best_sad_d = c_sad_ones;
      best_idx_d = '0;
      cand_cnt_d = '0;
      best_upd   = 1'b0;
    end

    result_valid_d = (state_d == ST_HOLD);
    busy_d         = (state_d == ST_TRACK) || (state_d == ST_DRAIN);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      done_dly_q     <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_sad_q       <= '0;
      s1_idx_q       <= '0;
      best_sad_q     <= c_sad_ones;
      best_idx_q     <= '0;
      cand_cnt_q     <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      done_dly_q     <= done_dly_d;
      s1_valid_q     <= s1_valid_d;
      s1_sad_q       <= s1_sad_d;
      s1_idx_q       <= s1_idx_d;
      best_sad_q     <= best_sad_d;
      best_idx_q     <= best_idx_d;
      cand_cnt_q     <= cand_cnt_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign result_valid = result_valid_q;
  assign best_sad     = best_sad_q;
  assign best_index   = best_idx_q;
  assign cand_count   = cand_cnt_q;
  assign busy         = busy_q;

`ifdef EARLY_EXIT_EN
  logic early_stop_q, early_stop_d;
  logic early_fired_q, early_fired_d;

  // Early-exit pulse: first qualifying best-SAD update per search only
  always_comb begin
    early_stop_d  = 1'b0;
    early_fired_d = early_fired_q;
    if (init) begin
      early_fired_d = 1'b0;
    end else if (best_upd && !early_fired_q && (s1_sad_q <= c_thresh)) begin
      early_stop_d  = 1'b1;
      early_fired_d = 1'b1;
    end
  end

  // Early-exit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      early_stop_q  <= 1'b0;
      early_fired_q <= 1'b0;
    end else begin
      early_stop_q  <= early_stop_d;
      early_fired_q <= early_fired_d;
    end
  end

  assign early_stop = early_stop_q;
`else
  // Threshold has no consumer when early exit is compiled out
  logic unused_thresh;
  assign unused_thresh = (^c_thresh) ^ best_upd;
  assign early_stop    = 1'b0;
`endif

endmodule
`default_nettype wire
